// File: rtl/ramwriter_mc.sv
// Multi-channel sample writer for one block-RAM write port: every PERIOD clocks it
// emits one word of live samples or a counting pattern, with wrap/stop addressing.
module ramwriter_mc #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned BASE_ADDR   = 1,
    parameter int unsigned INIT_CYCLES = 5,
    parameter int unsigned PERIOD      = 500000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_enable,
    input  logic                           i_mode_wrap,
    input  logic                           i_pattern,
    input  logic [CHANNELS-1:0]            i_ch_mask,
    input  logic [CHANNELS*SAMPLE_W-1:0]   i_sample,
    output logic [CHANNELS*SAMPLE_W-1:0]   o_data,
    output logic [ADDR_W-1:0]              o_address,
    output logic [CHANNELS*SAMPLE_W/8-1:0] o_byteen,
    output logic                           o_wbit,
    output logic                           o_done,
    output logic [31:0]                    o_count
);

    localparam int unsigned LANE_BYTES = SAMPLE_W / 8;
    localparam int unsigned BE_W       = CHANNELS * LANE_BYTES;
    localparam int unsigned CNT_MAX    = (INIT_CYCLES > PERIOD) ? INIT_CYCLES : PERIOD;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_A     = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    // WRITE plus WAIT cycles 0..PERIOD-2 spaces strobes exactly PERIOD clocks apart
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(PERIOD - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [SAMPLE_W-1:0]     pat_r;
    logic                    wrap_r;
    logic                    pattern_r;
    logic [CHANNELS-1:0]     mask_r;
    logic [CHANNELS*SAMPLE_W-1:0] data_s;
    logic [BE_W-1:0]         byteen_s;

    // Word and byte-enables to be loaded on the edge that enters WRITE
    always_comb begin
        data_s   = '0;
        byteen_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (pattern_r) begin
                data_s[k*SAMPLE_W +: SAMPLE_W] = pat_r + SAMPLE_W'(k);
            end else begin
                data_s[k*SAMPLE_W +: SAMPLE_W] = i_sample[k*SAMPLE_W +: SAMPLE_W];
            end
            byteen_s[k*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{mask_r[k]}};
        end
    end

    // Sequencer FSM with all RAM-port and status outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            pat_r     <= '0;
            wrap_r    <= 1'b0;
            pattern_r <= 1'b0;
            mask_r    <= '0;
            o_data    <= '0;
            o_address <= BASE_A;
            o_byteen  <= '0;
            o_wbit    <= 1'b0;
            o_done    <= 1'b0;
            o_count   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_enable) begin
                        wrap_r    <= i_mode_wrap;
                        pattern_r <= i_pattern;
                        mask_r    <= i_ch_mask;
                        o_address <= BASE_A;
                        o_count   <= 32'd0;
                        o_done    <= 1'b0;
                        pat_r     <= '0;
                        cnt_r     <= '0;
                        state_r   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (!i_enable) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == INIT_LAST) begin
                        cnt_r    <= '0;
                        o_data   <= data_s;
                        o_byteen <= byteen_s;
                        o_wbit   <= 1'b1;
                        state_r  <= ST_WRITE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    o_wbit <= 1'b0;
                    pat_r  <= pat_r + SAMPLE_W'(CHANNELS);
                    if (o_count != 32'hFFFF_FFFF) begin
                        o_count <= o_count + 32'd1;
                    end else begin
                        o_count <= o_count;
                    end
                    if (o_address != TOP_A) begin
                        o_address <= o_address + ADDR_W'(1);
                        state_r   <= i_enable ? ST_WAIT : ST_IDLE;
                    end else if (wrap_r) begin
                        o_address <= BASE_A;
                        state_r   <= i_enable ? ST_WAIT : ST_IDLE;
                    end else begin
                        o_done  <= 1'b1;
                        state_r <= i_enable ? ST_DONE : ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!i_enable) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == WAIT_LAST) begin
                        cnt_r    <= '0;
                        o_data   <= data_s;
                        o_byteen <= byteen_s;
                        o_wbit   <= 1'b1;
                        state_r  <= ST_WRITE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!i_enable) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_wbit  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramwriter_mc.sv
// Scoreboard bench for ramwriter_mc: two instances (PERIOD=4/BASE=1 and PERIOD=2/BASE=14)
// with expected strobes queued at stimulus time and compared as they appear.
module tb_ramwriter_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en2;
    logic        wrap;
    logic        pat;
    logic [3:0]  mask;
    logic [63:0] sample;

    logic [63:0] data1, data2;
    logic [3:0]  addr1, addr2;
    logic [7:0]  be1, be2;
    logic        wbit1, wbit2, done1, done2;
    logic [31:0] count1, count2;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
        int          cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    ramwriter_mc #(.CHANNELS(4), .SAMPLE_W(16), .ADDR_W(4), .BASE_ADDR(1),
                   .INIT_CYCLES(3), .PERIOD(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode_wrap(wrap),
        .i_pattern(pat), .i_ch_mask(mask), .i_sample(sample),
        .o_data(data1), .o_address(addr1), .o_byteen(be1), .o_wbit(wbit1),
        .o_done(done1), .o_count(count1));

    ramwriter_mc #(.CHANNELS(4), .SAMPLE_W(16), .ADDR_W(4), .BASE_ADDR(14),
                   .INIT_CYCLES(3), .PERIOD(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_mode_wrap(wrap),
        .i_pattern(pat), .i_ch_mask(mask), .i_sample(sample),
        .o_data(data2), .o_address(addr2), .o_byteen(be2), .o_wbit(wbit2),
        .o_done(done2), .o_count(count2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [63:0] patw(input int base);
        logic [63:0] w;
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    function automatic exp_t mk(input int c, input logic [3:0] a, input logic [63:0] d,
                                input logic [7:0] b, input int n);
        exp_t e;
        e.cyc = c; e.addr = a; e.data = d; e.be = b; e.cnt = n;
        return e;
    endfunction

    // Strobe monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (wbit1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("extra_strobe1", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("cyc1", 64'(cyc), 64'(e.cyc));
                chk("addr1", 64'(addr1), 64'(e.addr));
                chk("data1", data1, e.data);
                chk("be1", 64'(be1), 64'(e.be));
                chk("cnt1", 64'(count1), 64'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (wbit2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("extra_strobe2", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("cyc2", 64'(cyc), 64'(e.cyc));
                chk("addr2", 64'(addr2), 64'(e.addr));
                chk("data2", data2, e.data);
                chk("be2", 64'(be2), 64'(e.be));
                chk("cnt2", 64'(count2), 64'(e.cnt));
            end
        end
    end

    initial begin
        int n0;
        logic [3:0] a;
        logic [63:0] s1;
        logic [63:0] s2;
        s1 = 64'hDDDD_CCCC_BBBB_AAAA;
        s2 = 64'h1234_5678_9ABC_DEF0;
        rst = 1'b1; en = 1'b0; en2 = 1'b0; wrap = 1'b1; pat = 1'b0;
        mask = 4'h0; sample = 64'd0;
        repeat (3) tick();
        chk("rst_addr1", 64'(addr1), 64'd1);
        chk("rst_addr2", 64'(addr2), 64'd14);
        chk("rst_wbit", 64'(wbit1), 64'd0);
        chk("rst_data", data1, 64'd0);
        chk("rst_be", 64'(be1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_count", 64'(count1), 64'd0);
        rst = 1'b0;
        tick();

        // Wrap-mode pattern run: 16 strobes, addresses 1..15 then 1
        wrap = 1'b1; pat = 1'b1; mask = 4'hF; en = 1'b1; n0 = cyc;
        a = 4'd1;
        for (int i = 0; i < 16; i++) begin
            q1.push_back(mk(n0 + 4 + 4*i, a, patw(4*i), 8'hFF, i));
            a = (a == 4'd15) ? 4'd1 : a + 4'd1;
        end
        run_until(n0 + 66);
        chk("wrap_count", 64'(count1), 64'd16);
        chk("wrap_done", 64'(done1), 64'd0);
        chk("wrap_q", 64'(q1.size()), 64'd0);
        en = 1'b0;
        run_until(n0 + 80);
        chk("wait_drop_addr", 64'(addr1), 64'd2);
        chk("wait_drop_q", 64'(q1.size()), 64'd0);

        // Stop-mode run: 15 strobes then DONE
        wrap = 1'b0; pat = 1'b1; mask = 4'hF; en = 1'b1; n0 = cyc;
        for (int i = 0; i < 15; i++)
            q1.push_back(mk(n0 + 4 + 4*i, 4'(1 + i), patw(4*i), 8'hFF, i));
        run_until(n0 + 161);
        chk("stop_done", 64'(done1), 64'd1);
        chk("stop_count", 64'(count1), 64'd15);
        chk("stop_addr", 64'(addr1), 64'd15);
        chk("stop_q", 64'(q1.size()), 64'd0);
        en = 1'b0;
        tick(); tick();
        chk("idle_done", 64'(done1), 64'd1);

        // Live mode, mask 0101; sample change and config toggles mid-run
        pat = 1'b0; mask = 4'b0101; sample = s1; wrap = 1'b1; en = 1'b1; n0 = cyc;
        for (int i = 0; i < 4; i++)
            q1.push_back(mk(n0 + 4 + 4*i, 4'(1 + i), (i < 2) ? s1 : s2, 8'h33, i));
        tick();
        chk("restart_done", 64'(done1), 64'd0);
        chk("restart_addr", 64'(addr1), 64'd1);
        run_until(n0 + 9);
        mask = 4'hF; pat = 1'b1; wrap = 1'b0;
        run_until(n0 + 11);
        sample = s2;
        run_until(n0 + 16);
        en = 1'b0;
        tick();
        chk("wr_drop_wbit", 64'(wbit1), 64'd0);
        chk("wr_drop_count", 64'(count1), 64'd4);
        chk("wr_drop_addr", 64'(addr1), 64'd5);
        run_until(n0 + 30);
        chk("wr_drop_q", 64'(q1.size()), 64'd0);

        // Reset asserted during the WRITE cycle
        wrap = 1'b1; pat = 1'b1; mask = 4'b0101; en = 1'b1; n0 = cyc;
        q1.push_back(mk(n0 + 4, 4'd1, patw(0), 8'h33, 0));
        run_until(n0 + 4);
        rst = 1'b1;
        tick();
        chk("rstw_wbit", 64'(wbit1), 64'd0);
        chk("rstw_addr", 64'(addr1), 64'd1);
        chk("rstw_count", 64'(count1), 64'd0);
        chk("rstw_done", 64'(done1), 64'd0);
        rst = 1'b0; en = 1'b0;
        run_until(n0 + 20);
        chk("rstw_q", 64'(q1.size()), 64'd0);

        // PERIOD=2, BASE=14: strobes every other cycle, wrapping 14,15,14...
        pat = 1'b1; mask = 4'hF; wrap = 1'b1; en2 = 1'b1; n0 = cyc;
        a = 4'd14;
        for (int i = 0; i < 5; i++) begin
            q2.push_back(mk(n0 + 4 + 2*i, a, patw(4*i), 8'hFF, i));
            a = (a == 4'd15) ? 4'd14 : a + 4'd1;
        end
        run_until(n0 + 12);
        en2 = 1'b0;
        tick();
        chk("p2_count", 64'(count2), 64'd5);
        chk("p2_addr", 64'(addr2), 64'd15);
        run_until(n0 + 24);
        chk("p2_q", 64'(q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
